duty_ramp: RTL and testbench
============================

Name: duty_ramp

Overview:
Soft-start and slew-limited duty-cycle source that sits directly upstream of the PWM generator and drives its 8-bit duty input.
- Accepts a new target duty over a valid/ready handshake.
- Moves its registered dc output toward the target by at most STEP counts, once every PERIODS_PER_STEP PWM periods. Timing comes from a period_start pulse produced by the PWM counter wrap.
- Provides an immediate kill-to-zero path for fault shutdown.

Parameters:
WIDTH, 8, width of target and dc
STEP, 1, maximum dc change per step (1..2^WIDTH-1)
PERIODS_PER_STEP, 4, number of period_start pulses per step (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
target  input  WIDTH  requested duty cycle
target_valid  input  1  target is valid this cycle
target_ready  output  1  block can accept target
period_start  input  1  one-cycle pulse at PWM counter wrap
kill  input  1  synchronous force-to-zero, level sensitive
dc  output  WIDTH  registered duty cycle to PWM
busy  output  1  ramp in progress (dc != target register)
done  output  1  one-cycle pulse when dc reaches target

Behaviour:
- Reset (async assert, sync release): dc=0, tgt_reg=0, pcnt=0, state=IDLE, done=0. target_ready=0 while reset is high.
- target_ready = !kill out of reset (combinational). Accept = target_valid & target_ready. On accept, tgt_reg <= target on the next edge and overwrites any previous target.
- States:
  - IDLE (dc==tgt_reg)
  - UP (dc<tgt_reg)
  - DOWN (dc>tgt_reg)
- State is registered and re-evaluated every cycle from dc and tgt_reg after updates. busy = (state!=IDLE).
- Prescaler pcnt, range 0..PERIODS_PER_STEP-1:
  - Advances only on period_start while state!=IDLE.
  - Held at 0 in IDLE.
- Step event = period_start & state!=IDLE & pcnt==PERIODS_PER_STEP-1. On a step event, pcnt <= 0.
- Step arithmetic, done at WIDTH+1 bits with no wrap-around:
  - UP: dc <= dc + min(STEP, tgt_reg-dc).
  - DOWN: dc <= dc - min(STEP, dc-tgt_reg).
  - dc never overshoots tgt_reg.
- done pulses for exactly 1 cycle, the cycle after dc is written equal to tgt_reg by a step.
  - An accepted target equal to the current dc causes no done pulse and no state change.
- Latency:
  - Accept to first dc change: 1 to PERIODS_PER_STEP period_start pulses, depending on pcnt phase.
  - dc changes exactly 1 cycle after the qualifying period_start edge.
- Simultaneous accept and step: the step uses the old tgt_reg. The new tgt_reg takes effect next cycle; pcnt is not reset by the accept.
- Retarget reversing direction mid-ramp: state flips UP<->DOWN, and pcnt keeps its count.
- kill high:
  - Next edge: dc<=0, tgt_reg<=0, pcnt<=0, state<=IDLE, done<=0.
  - Held every cycle while kill stays high; target is ignored.
- Reset mid-ramp: all registers return immediately (asynchronously) to reset values. No done pulse.
- period_start asserted every cycle is legal. The ramp then runs at one step per PERIODS_PER_STEP clocks.

Test Plan:
1. Defaults, reset, accept target=10 with period_start every 256 clocks -> dc increments 0→1→...→10, one step per 4 pulses. busy=1 throughout, done single pulse after dc=10, then busy=0.
2. STEP=3, PERIODS_PER_STEP=1, target 0→10 -> dc sequence 3,6,9,10 (clamped). Then target=2 -> dc 7,4,2, with done after reaching 2.
3. Ramp up toward 200; at dc=50 accept target=20 in the same cycle as a step event -> that step still goes to 51, then dc descends to 20; no done pulse at 50/51.
4. Mid-ramp at dc=80, assert kill for 3 cycles while target_valid=1 with target=255 -> dc=0 one cycle after kill; target_ready=0 during kill; tgt_reg stays 0; busy=0 after release.
5. Assert reset asynchronously between clock edges mid-ramp -> dc=0, busy=0, done=0 immediately. After release, target_valid is accepted on the first edge.
6. Target equal to current dc (dc=0, target=0) and period_start every cycle -> dc stays 0, busy=0, no done pulse, pcnt stays 0.

Source files
------------

// File: rtl/duty_ramp.sv
// rtl/duty_ramp.sv - slew-limited duty-cycle source feeding the PWM duty input
module duty_ramp #(
  parameter int WIDTH            = 8,
  parameter int STEP             = 1,
  parameter int PERIODS_PER_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic             period_start,
  input  logic             kill,
  output logic [WIDTH-1:0] dc,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  localparam int              PW        = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [PW-1:0]    PCNT_LAST = PW'(PERIODS_PER_STEP - 1);
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);

  logic [WIDTH-1:0] tgt_reg;
  logic [1:0]       state;
  logic [PW-1:0]    pcnt;

  logic             accept;
  logic             step;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] dc_next;
  logic [WIDTH-1:0] tgt_next;
  logic [1:0]       state_next;
  logic [PW-1:0]    pcnt_next;
  logic             done_next;

  assign target_ready = !kill && !reset;
  assign busy         = (state != IDLE);

  always_comb begin
    accept   = target_valid && target_ready;
    step     = period_start && (state != IDLE) && (pcnt == PCNT_LAST);
    diff     = (state == DOWN) ? (dc - tgt_reg) : (tgt_reg - dc);
    // Clamping to the remaining distance keeps the add/subtract from ever wrapping.
    delta    = (diff < STEP_W) ? diff : STEP_W;
    dc_next  = dc;
    if (step && state == UP)
      dc_next = dc + delta;
    else if (step && state == DOWN)
      dc_next = dc - delta;

    // A target accepted alongside a step only takes effect after that step.
    tgt_next = accept ? target : tgt_reg;

    if (dc_next == tgt_next)
      state_next = IDLE;
    else if (dc_next < tgt_next)
      state_next = UP;
    else
      state_next = DOWN;

    if (state_next == IDLE || step)
      pcnt_next = '0;
    else if (period_start && state != IDLE)
      pcnt_next = pcnt + PW'(1);
    else
      pcnt_next = pcnt;

    done_next = step && (dc_next == tgt_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc      <= '0;
      tgt_reg <= '0;
      pcnt    <= '0;
      state   <= IDLE;
      done    <= 1'b0;
    end else if (kill) begin
      dc      <= '0;
      tgt_reg <= '0;
      pcnt    <= '0;
      state   <= IDLE;
      done    <= 1'b0;
    end else begin
      dc      <= dc_next;
      tgt_reg <= tgt_next;
      pcnt    <= pcnt_next;
      state   <= state_next;
      done    <= done_next;
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// tb/tb_duty_ramp.sv - randomized bench for duty_ramp against a behavioural ramp model
module tb_duty_ramp;
  localparam int W    = 8;
  localparam int STEP = 3;
  localparam int PPS  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] target = '0;
  logic         target_valid = 1'b0;
  logic         target_ready;
  logic         period_start = 1'b0;
  logic         kill = 1'b0;
  logic [W-1:0] dc;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  int m_dc, m_tgt, m_cnt;
  bit m_done;

  always #5 clk = ~clk;

  duty_ramp #(.WIDTH(W), .STEP(STEP), .PERIODS_PER_STEP(PPS)) u_dut (
    .clk(clk), .reset(reset), .target(target), .target_valid(target_valid),
    .target_ready(target_ready), .period_start(period_start), .kill(kill),
    .dc(dc), .busy(busy), .done(done)
  );

  task automatic model_reset();
    m_dc = 0; m_tgt = 0; m_cnt = 0; m_done = 0;
  endtask

  // Counts PWM periods while off target; every PPS-th one moves dc toward target by up to STEP.
  task automatic model_edge(input bit tv, input int t, input bit ps, input bit k);
    int  d, mv;
    bit  stepped;
    if (k) begin
      model_reset();
      return;
    end
    stepped = 0;
    if (m_dc != m_tgt && ps) begin
      if (m_cnt == PPS - 1) begin
        stepped = 1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (stepped) begin
      d  = m_tgt - m_dc;
      mv = (d > 0) ? d : -d;
      if (mv > STEP) mv = STEP;
      m_dc += (d > 0) ? mv : -mv;
    end
    if (tv) m_tgt = t;
    m_done = stepped && (m_dc == m_tgt);
    if (m_dc == m_tgt) m_cnt = 0;
  endtask

  task automatic cycle(input bit tv, input int t, input bit ps, input bit k);
    logic [W-1:0] exp_dc;
    target_valid = tv; target = t[W-1:0]; period_start = ps; kill = k;
    #1;
    checks++;
    if (target_ready !== !k) begin
      errors++;
      $display("FAIL ready actual=%0b required=%0b", target_ready, !k);
    end
    @(posedge clk);
    model_edge(tv, t, ps, k);
    #1;
    exp_dc = m_dc[W-1:0];
    checks++;
    if (dc !== exp_dc) begin
      errors++;
      $display("FAIL dc actual=%0d required=%0d at %0t", dc, exp_dc, $time);
    end
    checks++;
    if (busy !== (m_dc != m_tgt)) begin
      errors++;
      $display("FAIL busy actual=%0b required=%0b at %0t", busy, (m_dc != m_tgt), $time);
    end
    checks++;
    if (done !== m_done) begin
      errors++;
      $display("FAIL done actual=%0b required=%0b at %0t", done, m_done, $time);
    end
    if (done === 1'b1) done_seen++;
  endtask

  task automatic run_to(input int gap, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (m_dc == m_tgt) break;
      cycle(0, 0, (i % gap) == (gap - 1), 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dc !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state actual dc=%0d busy=%0b done=%0b required 0/0/0", dc, busy, done);
    end
    checks++;
    if (target_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready actual=%0b required=0", target_ready);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_ramp_up();
    done_seen = 0;
    cycle(1, 10, 0, 0);
    run_to(16, 2000);
    cycle(0, 0, 0, 0);
    checks++;
    if (dc !== 8'd10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ramp_up_end actual dc=%0d busy=%0b required dc=10 busy=0", dc, busy);
    end
    checks++;
    if (done_seen != 1) begin
      errors++;
      $display("FAIL ramp_up_done actual=%0d pulses required=1", done_seen);
    end
  endtask

  task automatic test_clamp_down();
    done_seen = 0;
    cycle(1, 2, 1, 0);
    run_to(1, 200);
    cycle(0, 0, 1, 0);
    checks++;
    if (dc !== 8'd2 || done_seen != 1) begin
      errors++;
      $display("FAIL clamp_down actual dc=%0d done=%0d required dc=2 done=1", dc, done_seen);
    end
  endtask

  task automatic test_retarget_on_step();
    int prev;
    cycle(1, 200, 1, 0);
    for (int i = 0; i < 500; i++) begin
      if (m_dc >= 48 && m_cnt == PPS - 1) break;
      cycle(0, 0, 1, 0);
    end
    prev = m_dc;
    done_seen = 0;
    cycle(1, 20, 1, 0);
    checks++;
    if (dc !== W'(prev + STEP) || done !== 1'b0) begin
      errors++;
      $display("FAIL retarget_step actual dc=%0d done=%0b required dc=%0d done=0", dc, done, prev + STEP);
    end
    run_to(1, 1000);
    checks++;
    if (dc !== 8'd20 || done_seen != 1) begin
      errors++;
      $display("FAIL retarget_end actual dc=%0d done=%0d required dc=20 done=1", dc, done_seen);
    end
  endtask

  task automatic test_kill();
    cycle(1, 200, 1, 0);
    for (int i = 0; i < 500; i++) begin
      if (m_dc >= 30) break;
      cycle(0, 0, 1, 0);
    end
    for (int i = 0; i < 3; i++) cycle(1, 255, 1, 1);
    cycle(0, 0, 1, 0);
    checks++;
    if (dc !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL kill_release actual dc=%0d busy=%0b required 0/0", dc, busy);
    end
  endtask

  task automatic test_async_reset();
    cycle(1, 100, 1, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (dc !== '0 || busy !== 1'b0 || done !== 1'b0 || target_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset actual dc=%0d busy=%0b done=%0b ready=%0b required 0/0/0/0",
               dc, busy, done, target_ready);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(1, 9, 0, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_accept actual busy=%0b required=1", busy);
    end
  endtask

  task automatic test_equal_target();
    cycle(0, 0, 0, 1);
    done_seen = 0;
    cycle(1, 0, 1, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 0);
    checks++;
    if (done_seen != 0 || busy !== 1'b0 || dc !== '0) begin
      errors++;
      $display("FAIL equal_target actual done=%0d busy=%0b dc=%0d required 0/0/0", done_seen, busy, dc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 6) == 0, $urandom % 256, ($urandom % 3) == 0, ($urandom % 60) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp_down();
    test_retarget_on_step();
    test_kill();
    test_async_reset();
    test_equal_target();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
